pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter PC_W, default 16, program counter width in bits.
REQ-002 The block SHALL have parameter OFF_W, default 6, relative-jump offset width in bits (signed, 2..PC_W).
REQ-003 The block SHALL have parameter RAS_DEPTH, default 4, return-address stack entries (power of two, >=2).
REQ-004 The block SHALL have parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-005 The block SHALL have port Clk2  input  1  the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port updatePC  input  1  advance enable; low = hold all state.
REQ-008 The block SHALL have port jump  input  1  relative jump request.
REQ-009 The block SHALL have port offset  input  OFF_W  signed relative displacement.
REQ-010 The block SHALL have port jumpAbs  input  1  absolute jump request.
REQ-011 The block SHALL have port call  input  1  subroutine call: push return address, go to target.
REQ-012 The block SHALL have port ret  input  1  subroutine return: pop stack into PC.
REQ-013 The block SHALL have port target  input  PC_W  absolute destination for jumpAbs and call.
REQ-014 The block SHALL have port clrErr  input  1  clears sticky error flags.
REQ-015 The block SHALL have port PC  output  PC_W  current program counter (registered).
REQ-016 The block SHALL have port ras_count  output  $clog2(RAS_DEPTH)+1  valid stack entries.
REQ-017 The block SHALL have ports ras_empty, ras_full  output  1 each  combinational decode of ras_count (==0, ==RAS_DEPTH).
REQ-018 The block SHALL have ports ras_ovf, ras_unf  output  1 each  sticky overflow and underflow flags.

Function
REQ-019 The block SHALL sign-extend offset from OFF_W to PC_W before addition.
REQ-020 The block SHALL compute all PC arithmetic modulo 2^PC_W (0xFFFF+1 -> 0x0000 at default width; no carry out).
REQ-021 The block SHALL, when updatePC=0, hold PC, stack contents, ras_count and flags (except clrErr), ignoring jump/jumpAbs/call/ret.
REQ-022 The block SHALL, when updatePC=1, select next PC by fixed priority: ret > call > jumpAbs > jump > PC+1.
REQ-023 The block SHALL, on ret with ras_count>0, load PC from top entry and decrement ras_count, with 1-cycle latency (new PC visible after that edge).
REQ-024 The block SHALL, on ret with ras_count=0, set PC<=PC+1, leave ras_count at 0, and set ras_unf.
REQ-025 The block SHALL, on call (ret low), push PC+1 (mod 2^PC_W) and load PC<=target in the same edge.
REQ-026 The block SHALL, on call with ras_count<RAS_DEPTH, increment ras_count.
REQ-027 The block SHALL, on call with ras_count=RAS_DEPTH, overwrite the oldest entry (circular stack), hold ras_count at RAS_DEPTH, and set ras_ovf.
REQ-028 The block SHALL, when call and ret are both high, perform only the return; the call is dropped and no flag is set for it.
REQ-029 The block SHALL, on jumpAbs (no ret/call), load PC<=target without touching the stack.
REQ-030 The block SHALL, on jump (no higher request), load PC<=PC+sext(offset).
REQ-031 The block SHALL implement the stack as a RAS_DEPTH-entry array with a wrap-around top pointer; stack data is not reset.
REQ-032 The block SHALL, on clrErr=1, clear ras_ovf and ras_unf at the edge, with an error event in the same cycle taking precedence (flag stays/becomes 1).
REQ-033 The block SHALL act on clrErr regardless of updatePC.

Reset
REQ-034 The block SHALL, while reset=1, immediately force PC=RESET_VEC, ras_count=0, top pointer=0, ras_ovf=0, ras_unf=0, regardless of Clk2.
REQ-035 The block SHALL, on reset asserted mid-operation (including during a call/ret cycle), discard the pending update; the first update after deassertion starts from RESET_VEC.
REQ-036 The block SHALL present ras_empty=1, ras_full=0 throughout reset.

Verification
REQ-037 Reset then updatePC=1, no requests, 3 edges -> PC 0x0001, 0x0002, 0x0003; ras_empty=1.
REQ-038 PC=0x0010, jump=1, offset=6'b111100 (-4) -> PC=0x000C; offset=6'b011111 -> PC=0x002B; PC=0xFFFF with +1 -> 0x0000.
REQ-039 PC=0x0005, call target=0x0100 -> PC=0x0100, ras_count=1; ret -> PC=0x0006, ras_count=0, ras_empty=1.
REQ-040 Five nested calls from PCs 0x10,0x20,0x30,0x40,0x50 (RAS_DEPTH=4) -> ras_ovf=1, ras_count=4; four rets return 0x51,0x41,0x31,0x21; fifth ret -> PC+1, ras_unf=1; clrErr -> both flags 0.
REQ-041 call+ret+jumpAbs high with ras top=0x0033 -> PC=0x0033, ras_count decrements, no push; updatePC=0 with all requests high -> PC and ras_count unchanged.
REQ-042 Assert reset asynchronously between edges with PC=0x0123, ras_count=2 -> PC=0x0000, ras_count=0 before next Clk2 edge; parameter sweep PC_W=32, OFF_W=12, RAS_DEPTH=8 repeats REQ-038..040.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter sequencer with relative/absolute jumps and a circular return-address stack.
// Sticky overflow/underflow flags report stack misuse until cleared by clrErr.
module pc_sequencer #(
    parameter int               PC_W      = 16,
    parameter int               OFF_W     = 6,
    parameter int               RAS_DEPTH = 4,
    parameter logic [PC_W-1:0]  RESET_VEC = '0
) (
    input  logic                         Clk2,
    input  logic                         reset,
    input  logic                         updatePC,
    input  logic                         jump,
    input  logic [OFF_W-1:0]             offset,
    input  logic                         jumpAbs,
    input  logic                         call,
    input  logic                         ret,
    input  logic [PC_W-1:0]              target,
    input  logic                         clrErr,
    output logic [PC_W-1:0]              PC,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         ras_ovf,
    output logic                         ras_unf
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [PC_W-1:0]  stack_q [RAS_DEPTH];

    logic             push_en;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  off_sext;
    logic [PTR_W-1:0] top_dec;

    assign pc_inc   = pc_q + PC_W'(1);
    assign off_sext = PC_W'($signed(offset));
    assign top_dec  = top_q - PTR_W'(1);

    always_ff @(posedge Clk2 or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_VEC;
            top_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack payload is deliberately unreset; only the pointer and count define validity.
    always_ff @(posedge Clk2) begin
        if (push_en) begin
            stack_q[top_q] <= pc_inc;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        top_d   = top_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q & ~clrErr;
        unf_d   = unf_q & ~clrErr;
        push_en = 1'b0;
        if (updatePC) begin
            if (ret) begin
                if (cnt_q != '0) begin
                    pc_d  = stack_q[top_dec];
                    top_d = top_dec;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    pc_d  = pc_inc;
                    unf_d = 1'b1;
                end
            end else if (call) begin
                // When full, top_q already points at the oldest entry, so the push overwrites it.
                push_en = 1'b1;
                top_d   = top_q + PTR_W'(1);
                pc_d    = target;
                if (cnt_q == FULL_CNT) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (jumpAbs) begin
                pc_d = target;
            end else if (jump) begin
                pc_d = pc_q + off_sext;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    assign PC        = pc_q;
    assign ras_count = cnt_q;
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == FULL_CNT);
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Drives a default pc_sequencer and a wide one (32/12/8) in lockstep against a queue-based model.
module tb_pc_sequencer;

    logic        Clk2;
    logic        reset;
    logic        updatePC, jump, jumpAbs, call, ret, clrErr;
    logic [5:0]  offset0;
    logic [11:0] offset1;
    logic [15:0] target0;
    logic [31:0] target1;

    logic [15:0] PC0;
    logic [2:0]  cnt0;
    logic        empty0, full0, ovf0, unf0;
    logic [31:0] PC1;
    logic [3:0]  cnt1;
    logic        empty1, full1, ovf1, unf1;

    int n_checks = 0;
    int n_pass   = 0;

    pc_sequencer dut0 (
        .Clk2(Clk2), .reset(reset), .updatePC(updatePC), .jump(jump), .offset(offset0),
        .jumpAbs(jumpAbs), .call(call), .ret(ret), .target(target0), .clrErr(clrErr),
        .PC(PC0), .ras_count(cnt0), .ras_empty(empty0), .ras_full(full0),
        .ras_ovf(ovf0), .ras_unf(unf0)
    );

    pc_sequencer #(.PC_W(32), .OFF_W(12), .RAS_DEPTH(8)) dut1 (
        .Clk2(Clk2), .reset(reset), .updatePC(updatePC), .jump(jump), .offset(offset1),
        .jumpAbs(jumpAbs), .call(call), .ret(ret), .target(target1), .clrErr(clrErr),
        .PC(PC1), .ras_count(cnt1), .ras_empty(empty1), .ras_full(full1),
        .ras_ovf(ovf1), .ras_unf(unf1)
    );

    initial begin
        Clk2 = 1'b0;
        forever #5 Clk2 = ~Clk2;
    end

    // Reference model: PC value plus a queue of return addresses (back = most recent).
    longint unsigned m_pc [2];
    bit              m_ovf [2];
    bit              m_unf [2];
    longint unsigned q0 [$];
    longint unsigned q1 [$];

    function automatic int pcw(int k);   return (k == 0) ? 16 : 32; endfunction
    function automatic int offw(int k);  return (k == 0) ? 6 : 12;  endfunction
    function automatic int depth(int k); return (k == 0) ? 4 : 8;   endfunction

    function automatic int qsize(int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            longint unsigned mask;
            longint unsigned off;
            longint unsigned tgt;
            mask = (64'd1 << pcw(k)) - 64'd1;
            off  = (k == 0) ? 64'(offset0) : 64'(offset1);
            tgt  = (k == 0) ? 64'(target0) : 64'(target1);
            if (((off >> (offw(k) - 1)) & 64'd1) != 0) off = off - (64'd1 << offw(k));
            if (clrErr) begin
                m_ovf[k] = 0; m_unf[k] = 0;
            end
            if (updatePC) begin
                if (ret) begin
                    if (qsize(k) > 0) begin
                        m_pc[k] = (k == 0) ? q0.pop_back() : q1.pop_back();
                    end else begin
                        m_pc[k] = (m_pc[k] + 1) & mask;
                        m_unf[k] = 1;
                    end
                end else if (call) begin
                    if (k == 0) q0.push_back((m_pc[k] + 1) & mask);
                    else        q1.push_back((m_pc[k] + 1) & mask);
                    if (qsize(k) > depth(k)) begin
                        if (k == 0) void'(q0.pop_front());
                        else        void'(q1.pop_front());
                        m_ovf[k] = 1;
                    end
                    m_pc[k] = tgt & mask;
                end else if (jumpAbs) begin
                    m_pc[k] = tgt & mask;
                end else if (jump) begin
                    m_pc[k] = (m_pc[k] + off) & mask;
                end else begin
                    m_pc[k] = (m_pc[k] + 1) & mask;
                end
            end
        end
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic check_all(string tag);
        chk({tag, "/pc0"},    64'(PC0),    m_pc[0]);
        chk({tag, "/cnt0"},   64'(cnt0),   64'(qsize(0)));
        chk({tag, "/empty0"}, 64'(empty0), 64'(qsize(0) == 0));
        chk({tag, "/full0"},  64'(full0),  64'(qsize(0) == 4));
        chk({tag, "/ovf0"},   64'(ovf0),   64'(m_ovf[0]));
        chk({tag, "/unf0"},   64'(unf0),   64'(m_unf[0]));
        chk({tag, "/pc1"},    64'(PC1),    m_pc[1]);
        chk({tag, "/cnt1"},   64'(cnt1),   64'(qsize(1)));
        chk({tag, "/empty1"}, 64'(empty1), 64'(qsize(1) == 0));
        chk({tag, "/full1"},  64'(full1),  64'(qsize(1) == 8));
        chk({tag, "/ovf1"},   64'(ovf1),   64'(m_ovf[1]));
        chk({tag, "/unf1"},   64'(unf1),   64'(m_unf[1]));
    endtask

    // off/tgt given as 64-bit values; each instance takes its own low bits.
    task automatic drive(bit u, bit j, bit ja, bit c, bit r, bit cl,
                         logic [63:0] off, logic [63:0] tgt);
        updatePC = u; jump = j; jumpAbs = ja; call = c; ret = r; clrErr = cl;
        offset0 = off[5:0];  offset1 = off[11:0];
        target0 = tgt[15:0]; target1 = tgt[31:0];
    endtask

    task automatic step(string tag);
        model_step();
        @(posedge Clk2);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #3;
        check_all("reset");
        @(posedge Clk2);
        #1;
        check_all("reset_edge");
        reset = 1'b0;

        // Free-running increment
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            step("incr");
            chk("incr_pc", 64'(PC0), 64'(i));
        end
        chk("incr_empty", 64'(empty0), 64'd1);

        // Relative jumps and wrap
        drive(1, 0, 1, 0, 0, 0, 0, 64'h10);             step("abs10");
        drive(1, 1, 0, 0, 0, 0, -64'sd4, 0);            step("jmp_m4");
        chk("jmp_m4_pc", 64'(PC0), 64'h000C);
        drive(1, 1, 0, 0, 0, 0, 64'd31, 0);             step("jmp_p31");
        chk("jmp_p31_pc", 64'(PC0), 64'h002B);
        drive(1, 0, 1, 0, 0, 0, 0, 64'hFFFF_FFFF);      step("abs_max");
        drive(1, 0, 0, 0, 0, 0, 0, 0);                  step("wrap");
        chk("wrap_pc0", 64'(PC0), 64'h0);
        chk("wrap_pc1", 64'(PC1), 64'h0);

        // Single call / return
        drive(1, 0, 1, 0, 0, 0, 0, 64'h5);              step("abs5");
        drive(1, 0, 0, 1, 0, 0, 0, 64'h100);            step("call");
        chk("call_pc", 64'(PC0), 64'h100);
        chk("call_cnt", 64'(cnt0), 64'd1);
        drive(1, 0, 0, 0, 1, 0, 0, 0);                  step("ret");
        chk("ret_pc", 64'(PC0), 64'h6);
        chk("ret_empty", 64'(empty0), 64'd1);

        // Five nested calls: default instance overflows, wide one does not
        for (int i = 1; i <= 5; i++) begin
            drive(1, 0, 1, 0, 0, 0, 0, 64'(i * 16));    step("nest_abs");
            drive(1, 0, 0, 1, 0, 0, 0, 64'(512 + i));   step("nest_call");
        end
        chk("nest_ovf", 64'(ovf0), 64'd1);
        chk("nest_cnt", 64'(cnt0), 64'd4);
        chk("nest_full", 64'(full0), 64'd1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 1, 0, 0, 0);              step("nest_ret");
            chk("nest_ret_pc", 64'(PC0), 64'(16'h51 - 16 * i));
        end
        drive(1, 0, 0, 0, 1, 0, 0, 0);                  step("unf_ret");
        chk("unf_pc", 64'(PC0), 64'h22);
        chk("unf_flag", 64'(unf0), 64'd1);
        chk("unf_pc1", 64'(PC1), 64'h11);
        drive(0, 0, 0, 0, 0, 1, 0, 0);                  step("clr");
        chk("clr_ovf", 64'(ovf0), 64'd0);
        chk("clr_unf", 64'(unf0), 64'd0);

        // ret wins over call and jumpAbs; hold ignores everything
        drive(1, 0, 1, 0, 0, 0, 0, 64'h32);             step("pri_abs");
        drive(1, 0, 0, 1, 0, 0, 0, 64'h400);            step("pri_call");
        drive(1, 1, 1, 1, 1, 0, 64'd7, 64'h777);        step("pri_all");
        chk("pri_pc", 64'(PC0), 64'h33);
        chk("pri_cnt", 64'(cnt0), 64'd0);
        drive(0, 1, 1, 1, 1, 0, 64'd7, 64'h777);        step("hold");
        chk("hold_pc", 64'(PC0), 64'h33);

        // Asynchronous reset between edges, then held across a call edge
        drive(1, 0, 1, 0, 0, 0, 0, 64'h10);             step("ar_abs");
        drive(1, 0, 0, 1, 0, 0, 0, 64'h50);             step("ar_call1");
        drive(1, 0, 0, 1, 0, 0, 0, 64'h123);            step("ar_call2");
        chk("ar_pre_pc", 64'(PC0), 64'h123);
        chk("ar_pre_cnt", 64'(cnt0), 64'd2);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        chk("async_rst_pc", 64'(PC0), 64'h0);
        @(posedge Clk2);
        #1;
        check_all("rst_held_call");
        reset = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);                  step("post_rst");
        chk("post_rst_pc", 64'(PC0), 64'h1);

        // Randomized traffic with occasional mid-cycle reset pulses
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(3, 0) != 0, $urandom_range(3, 0) == 0,
                  $urandom_range(5, 0) == 0, $urandom_range(3, 0) == 0,
                  $urandom_range(3, 0) == 0, $urandom_range(9, 0) == 0,
                  {$urandom, $urandom}, {$urandom, $urandom});
            step("rand");
            if ($urandom_range(49, 0) == 0) begin
                #2;
                reset = 1'b1;
                model_reset();
                #1;
                check_all("rand_rst");
                #1;
                reset = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
